// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction ROM read port between fetch_stage (master) and imem (slave)
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage and IF/ID register with a one-entry skid buffer
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          IRD,
  output logic [31:0]          pc_ID,
  output logic                 valid_ID,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, HELD} state_t;

  state_t      state;
  logic [31:0] pc_F;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic        skid_valid;
  logic [31:0] skid_ir;
  logic [31:0] skid_pc;
  logic        req;

  // A full skid only exists while stall is low and drains the cycle stall rises,
  // so it never has to block the request that keeps the stream gap-free.
  assign req            = (state != IDLE) & stall & ~redirect & ~reset;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_F;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc_F        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      skid_valid  <= 1'b0;
      skid_ir     <= '0;
      skid_pc     <= '0;
      IRD         <= '0;
      pc_ID       <= '0;
      valid_ID    <= 1'b0;
    end else begin
      inflight <= req;
      if (req) begin
        pc_F        <= pc_F + 32'd4;
        inflight_pc <= pc_F;
      end
      if (redirect) begin
        // Any response landing this cycle belongs to the abandoned path.
        state      <= RUN;
        pc_F       <= {redirect_pc[31:2], 2'b00};
        IRD        <= '0;
        pc_ID      <= '0;
        valid_ID   <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE:    state <= RUN;
          RUN:     if (inflight && !stall) state <= HELD;
          HELD:    if (stall) state <= RUN;
          default: state <= IDLE;
        endcase
        if (stall) begin
          if (skid_valid) begin
            IRD        <= skid_ir;
            pc_ID      <= skid_pc + 32'd4;
            valid_ID   <= 1'b1;
            skid_valid <= 1'b0;
          end else if (inflight) begin
            IRD      <= imem.imem_rdata;
            pc_ID    <= inflight_pc + 32'd4;
            valid_ID <= 1'b1;
          end else begin
            IRD      <= '0;
            valid_ID <= 1'b0;
          end
        end else if (inflight) begin
          skid_valid <= 1'b1;
          skid_ir    <= imem.imem_rdata;
          skid_pc    <= inflight_pc;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!stall && valid_ID) stall_q <= stall_q + 32'd1;
      if (redirect)           flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage against a program-order model
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ROM_KEY  = 32'h3C00_00A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] IRD;
  logic [31:0] pc_ID;
  logic        valid_ID;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem       (imem_bus),
    .IRD        (IRD),
    .pc_ID      (pc_ID),
    .valid_ID   (valid_ID),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ ROM_KEY;
  endfunction

  // Synchronous ROM, fixed one-cycle latency.
  always @(posedge clk) begin
    if (imem_bus.imem_req) imem_bus.imem_rdata <= rom_word(imem_bus.imem_addr);
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tail_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Stimulus: inputs change at negedge; the program-order stream is queued here.
  task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] tgt);
    @(negedge clk);
    reset = r; stall = s; redirect = d; redirect_pc = tgt;
    if (r) begin
      exp_q.delete(); tail_pc = RESET_PC; exp_q.push_back(tail_pc);
    end else if (d) begin
      exp_q.delete(); tail_pc = {tgt[31:2], 2'b00}; exp_q.push_back(tail_pc);
    end
    while (exp_q.size() < 4) begin
      tail_pc = tail_pc + 32'd4;
      exp_q.push_back(tail_pc);
    end
  endtask

  task automatic run(input int n, input logic s);
    for (int i = 0; i < n; i++) drive(1'b0, s, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] t;
    reset = 1'b1; stall = 1'b1; redirect = 1'b0; redirect_pc = '0;
    tail_pc = RESET_PC;
    exp_q.push_back(RESET_PC);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    run(6, 1'b1);
    run(3, 1'b0);
    run(4, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    run(4, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    run(4, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    run(6, 1'b1);
    run(3, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    run(4, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    run(5, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_1233);
    run(4, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      t = $urandom();
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0, t);
    end
    run(4, 1'b1);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Monitor: model of what IF/ID must show after each edge.
  // After a redirect or the post-reset idle cycle, the second advancing cycle delivers,
  // and every advancing cycle after that delivers the next program-order word.
  logic        m_r, m_s, m_d;
  int          adv_cnt = 0;
  bit          in_idle = 1'b0;
  logic [31:0] last_ir = '0;
  logic [31:0] last_pc = '0;
  bit          last_pc_known = 1'b1;
  logic        last_valid = 1'b0;
  logic [31:0] exp_stall_cnt = '0;
  logic [31:0] exp_flush_cnt = '0;
  logic [31:0] e;

  task automatic expect_bubble();
    check("bubble_valid", {31'b0, valid_ID}, 32'd0);
    check("bubble_ird", IRD, 32'h0);
    last_ir = '0; last_valid = 1'b0; last_pc_known = 1'b0;
  endtask

  task automatic expect_hold();
    check("hold_valid", {31'b0, valid_ID}, {31'b0, last_valid});
    check("hold_ird", IRD, last_ir);
    if (last_pc_known) check("hold_pc_id", pc_ID, last_pc);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      m_r = reset; m_s = stall; m_d = redirect;
      #1;
      if (m_r) begin
        exp_stall_cnt = '0; exp_flush_cnt = '0;
      end else begin
        if (!m_s && last_valid) exp_stall_cnt = exp_stall_cnt + 32'd1;
        if (m_d)                exp_flush_cnt = exp_flush_cnt + 32'd1;
      end
`ifdef FETCH_PERF_CNT_EN
      check("stall_cnt", stall_cnt, exp_stall_cnt);
      check("flush_cnt", flush_cnt, exp_flush_cnt);
`else
      check("stall_cnt_tied", stall_cnt, 32'h0);
      check("flush_cnt_tied", flush_cnt, 32'h0);
`endif
      if (m_r) begin
        adv_cnt = 0; in_idle = 1'b1;
        check("rst_valid", {31'b0, valid_ID}, 32'd0);
        check("rst_ird", IRD, 32'h0);
        check("rst_pc_id", pc_ID, 32'h0);
        check("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
        check("rst_addr", imem_bus.imem_addr, RESET_PC);
        last_ir = '0; last_pc = '0; last_pc_known = 1'b1; last_valid = 1'b0;
      end else if (m_d) begin
        adv_cnt = 0; in_idle = 1'b0;
        check("flush_valid", {31'b0, valid_ID}, 32'd0);
        check("flush_ird", IRD, 32'h0);
        check("flush_pc_id", pc_ID, 32'h0);
        last_ir = '0; last_pc = '0; last_pc_known = 1'b1; last_valid = 1'b0;
      end else if (in_idle) begin
        in_idle = 1'b0;
        if (m_s) expect_bubble();
        else     expect_hold();
      end else if (m_s) begin
        adv_cnt++;
        if (adv_cnt >= 2) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL deliver_queue @%0t: got empty expected an entry", $time);
          end else begin
            e = exp_q.pop_front();
            check("deliver_valid", {31'b0, valid_ID}, 32'd1);
            check("deliver_ird", IRD, rom_word(e));
            check("deliver_pc_id", pc_ID, e + 32'd4);
            last_ir = rom_word(e); last_pc = e + 32'd4; last_pc_known = 1'b1; last_valid = 1'b1;
          end
        end else begin
          expect_bubble();
        end
      end else begin
        expect_hold();
      end
    end
  end
endmodule
